// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states and frame geometry.
package uart_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } rx_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous inputs, with a selectable reset value.
module sync_2ff #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with a one-entry valid/ready holding register,
// framing-error and overrun pulses.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 87
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rx,
  output logic [UART_DATA_BITS-1:0] rx_data,
  output logic                      rx_valid,
  input  logic                      rx_ready,
  output logic                      frame_err,
  output logic                      overrun,
  output logic                      busy
);

  localparam int             CW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0]  HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0]  FULL_LOAD = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]     LAST_BIT  = 3'(UART_DATA_BITS - 1);

  logic                      rx_s;
  rx_state_t                 state;
  logic [CW-1:0]             cnt;
  logic [2:0]                bit_idx;
  logic [UART_DATA_BITS-1:0] shreg;

  sync_2ff #(.WIDTH(1), .RST_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rx_s)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      // Handshake drains the holding register; a completion below may refill it.
      if (rx_valid && rx_ready) rx_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (!rx_s) begin
            cnt   <= HALF_LOAD;
            state <= START;
            busy  <= 1'b1;
          end
        end

        START: begin
          if (cnt == '0) begin
            if (rx_s) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              cnt     <= FULL_LOAD;
              bit_idx <= '0;
              state   <= DATA;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        DATA: begin
          if (cnt == '0) begin
            shreg   <= {rx_s, shreg[UART_DATA_BITS-1:1]};
            cnt     <= FULL_LOAD;
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == LAST_BIT) state <= STOP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        STOP: begin
          if (cnt == '0) begin
            if (rx_s) begin
              if (!rx_valid || rx_ready) begin
                rx_data  <= shreg;
                rx_valid <= 1'b1;
              end else begin
                overrun <= 1'b1;
              end
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              frame_err <= 1'b1;
              state     <= BREAK;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        BREAK: begin
          // A line held low must return high before another start is accepted.
          if (rx_s) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
